// File: rtl/pmem_load_ctrl_pkg.sv
// Shared types and default sizes for the program-memory load controller.
// The memory is a single port shared between CPU instruction fetch and host downloads.
package pmem_load_ctrl_pkg;

  localparam int PMEM_IA_W = 16;
  localparam int PMEM_ID_W = 24;

  typedef enum logic [1:0] {
    PLS_IDLE   = 2'd0,
    PLS_LOAD   = 2'd1,
    PLS_VERIFY = 2'd2,
    PLS_FIN    = 2'd3
  } pls_state_e;

endpackage

// File: rtl/pmem_load_ctrl_csum_acc.sv
// Modular (wrap-around) checksum accumulator with synchronous clear and enable.
// Clear has priority over enable.
module pmem_csum_acc
  import pmem_load_ctrl_pkg::*;
#(
  parameter int W = PMEM_ID_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/pmem_load_ctrl.sv
// Program-memory port owner: CPU fetch when idle; host download with write,
// read-back checksum verify and CPU halt otherwise.
//
// state      | meaning
// PLS_IDLE   | CPU owns the port, fetches pass straight through
// PLS_LOAD   | host words written at ptr, one per handshake
// PLS_VERIFY | one read-back per cycle, accumulating rsum
// PLS_FIN    | one-cycle DONE, then the CPU is released
module pmem_load_ctrl
  import pmem_load_ctrl_pkg::*;
#(
  parameter int IA_W     = PMEM_IA_W,
  parameter int ID_W     = PMEM_ID_W,
  parameter int MEM_SIZE = 1 << IA_W
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            CPU_REQ,
  input  logic [IA_W-1:0] CPU_A,
  output logic [ID_W-1:0] CPU_DQ,
  output logic            CPU_VALID,
  output logic            CPU_HALT,
  input  logic            HOST_START,
  input  logic            HOST_ABORT,
  input  logic [IA_W-1:0] HOST_BASE,
  input  logic [IA_W:0]   HOST_LEN,
  input  logic            HOST_DVALID,
  input  logic [ID_W-1:0] HOST_DI,
  output logic            HOST_DREADY,
  output logic            HOST_BUSY,
  output logic            HOST_DONE,
  output logic            HOST_ERR,
  output logic [IA_W-1:0] MEM_A,
  output logic            MEM_WE,
  output logic [ID_W-1:0] MEM_DI,
  input  logic [ID_W-1:0] MEM_DQ
);

  localparam logic [IA_W:0] SIZE_W = (IA_W+1)'(MEM_SIZE);
  localparam logic [IA_W:0] ONE    = (IA_W+1)'(1);

  pls_state_e      state_q, state_d;
  logic [IA_W-1:0] base_q, base_d;
  logic [IA_W:0]   len_q, len_d;
  logic [IA_W:0]   ptr_q, ptr_d;
  logic [IA_W:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            halt_q, halt_d;

  logic            wsum_clr, wsum_en, rsum_clr, rsum_en;
  logic [ID_W-1:0] wsum, rsum, rsum_nxt;
  logic [IA_W:0]   end_addr, cnt_inc;
  logic            range_bad;

  // IA_W+1 bits so base+len==MEM_SIZE (ending on the last word) stays legal
  assign end_addr  = {1'b0, HOST_BASE} + HOST_LEN;
  assign range_bad = end_addr > SIZE_W;
  assign cnt_inc   = cnt_q + ONE;
  assign rsum_nxt  = rsum + MEM_DQ;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wsum_clr    = 1'b0;
    wsum_en     = 1'b0;
    rsum_clr    = 1'b0;
    rsum_en     = 1'b0;
    MEM_A       = CPU_A;
    MEM_WE      = 1'b0;
    HOST_DREADY = 1'b0;
    CPU_VALID   = 1'b0;

    case (state_q)
      PLS_IDLE: begin
        CPU_VALID = CPU_REQ;
        if (HOST_START) begin
          err_d    = 1'b0;
          base_d   = HOST_BASE;
          len_d    = HOST_LEN;
          ptr_d    = {1'b0, HOST_BASE};
          cnt_d    = '0;
          wsum_clr = 1'b1;
          rsum_clr = 1'b1;
          if (HOST_LEN == '0) begin
            state_d = PLS_FIN;
          end else if (range_bad) begin
            state_d = PLS_FIN;
            err_d   = 1'b1;
          end else begin
            state_d = PLS_LOAD;
          end
        end
      end
      PLS_LOAD: begin
        HOST_DREADY = 1'b1;
        MEM_A       = ptr_q[IA_W-1:0];
        // abort wins over a same-cycle handshake: that word is dropped
        if (HOST_ABORT) begin
          state_d = PLS_FIN;
          err_d   = 1'b1;
        end else if (HOST_DVALID) begin
          MEM_WE  = 1'b1;
          wsum_en = 1'b1;
          ptr_d   = ptr_q + ONE;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = PLS_VERIFY;
            ptr_d   = {1'b0, base_q};
            cnt_d   = '0;
          end
        end
      end
      PLS_VERIFY: begin
        MEM_A = ptr_q[IA_W-1:0];
        if (HOST_ABORT) begin
          state_d = PLS_FIN;
          err_d   = 1'b1;
        end else begin
          rsum_en = 1'b1;
          ptr_d   = ptr_q + ONE;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = PLS_FIN;
            err_d   = err_q | (rsum_nxt != wsum);
          end
        end
      end
      PLS_FIN: begin
        state_d = PLS_IDLE;
      end
      default: begin
        state_d = PLS_IDLE;
      end
    endcase

    halt_d = (state_d != PLS_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= PLS_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  pmem_csum_acc #(.W(ID_W)) u_wsum (
    .clk   (CLK),
    .rst_n (RSTn),
    .clr   (wsum_clr),
    .en    (wsum_en),
    .din   (HOST_DI),
    .sum   (wsum)
  );

  pmem_csum_acc #(.W(ID_W)) u_rsum (
    .clk   (CLK),
    .rst_n (RSTn),
    .clr   (rsum_clr),
    .en    (rsum_en),
    .din   (MEM_DQ),
    .sum   (rsum)
  );

  assign CPU_DQ    = MEM_DQ;
  assign CPU_HALT  = halt_q;
  assign HOST_BUSY = halt_q;
  assign HOST_DONE = (state_q == PLS_FIN);
  assign HOST_ERR  = err_q;
  assign MEM_DI    = HOST_DI;

endmodule
